// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencing FSM.
// Each cycle it chooses the next fetch address. The priority is reset, then
// halt, then jump, then branch, then stall, then sequential increment.
// All outputs are registered. A request sampled at edge N shows up on
// pc_next/pc_en after that edge, so the PC register captures it at edge N+1.
module pc_sequencer #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter logic [15:0] INC       = 16'h0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        halt,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jmp,
    input  logic [15:0] jmp_addr,
    output logic [15:0] pc_next,
    output logic        pc_en,
    output logic        flush,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        HALT  = 2'b11
    } state_t;

    state_t st;

    assign state = st;

    // Single-process FSM. pc_next doubles as the address accumulator, so
    // branches are taken relative to the address most recently presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            pc_next <= RESET_VEC;
            pc_en   <= 1'b0;
            flush   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    flush <= 1'b0;
                    if (start) begin
                        st      <= RUN;
                        pc_next <= RESET_VEC;
                        pc_en   <= 1'b1;
                    end else begin
                        pc_en <= 1'b0;
                    end
                end
                RUN, STALL: begin
                    if (halt) begin
                        st    <= HALT;
                        pc_en <= 1'b0;
                        flush <= 1'b0;
                    end else if (jmp) begin
                        st      <= RUN;
                        pc_next <= jmp_addr;
                        pc_en   <= 1'b1;
                        flush   <= 1'b1;
                    end else if (br_taken) begin
                        st      <= RUN;
                        pc_next <= pc_next + br_offset;
                        pc_en   <= 1'b1;
                        flush   <= 1'b1;
                    end else if (stall) begin
                        st    <= STALL;
                        pc_en <= 1'b0;
                        flush <= 1'b0;
                    end else begin
                        st      <= RUN;
                        pc_next <= pc_next + INC;
                        pc_en   <= 1'b1;
                        flush   <= 1'b0;
                    end
                end
                default: begin
                    // HALT is absorbing; only rst leaves it.
                    pc_en <= 1'b0;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. The driver applies inputs on the falling edge
// and pushes the expected post-edge outputs from a behavioural model into a
// queue. The monitor compares the DUT against that queue after each rising edge.
module tb_pc_sequencer;

    localparam logic [15:0] RV  = 16'h0000;
    localparam int          INC = 1;

    logic        clk = 1'b0;
    logic        rst, start, stall, halt, br_taken, jmp;
    logic [15:0] br_offset, jmp_addr;
    logic [15:0] pc_next;
    logic        pc_en, flush;
    logic [1:0]  state;

    typedef struct {
        int    st;
        int    pc;
        bit    en;
        bit    fl;
        string tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: mode 0 idle, 1 run, 2 stall, 3 halt. The PC is an int in 0..65535.
    int m_mode = 0;
    int m_pc   = 0;
    bit m_en   = 0;
    bit m_fl   = 0;

    pc_sequencer #(.RESET_VEC(RV), .INC(16'(INC))) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .halt(halt),
        .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp),
        .jmp_addr(jmp_addr), .pc_next(pc_next), .pc_en(pc_en),
        .flush(flush), .state(state)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the rules for the current mode.
    task automatic model(input bit r, s, st_i, h, b, input int off, input bit j, input int ja);
        if (r) begin
            m_mode = 0; m_pc = int'(RV); m_en = 0; m_fl = 0;
        end else if (m_mode == 0) begin
            m_fl = 0;
            m_en = s;
            if (s) begin m_mode = 1; m_pc = int'(RV); end
        end else if (m_mode == 3) begin
            m_en = 0; m_fl = 0;
        end else if (h) begin
            m_mode = 3; m_en = 0; m_fl = 0;
        end else if (j || b) begin
            m_pc   = j ? ja : (m_pc + off) % 65536;
            m_mode = 1; m_en = 1; m_fl = 1;
        end else if (st_i) begin
            m_mode = 2; m_en = 0; m_fl = 0;
        end else begin
            m_pc   = (m_pc + INC) % 65536;
            m_mode = 1; m_en = 1; m_fl = 0;
        end
    endtask

    // Drive one cycle of inputs and queue the expectation. If glitch is set,
    // rst is pulsed between edges, which the DUT must ignore.
    task automatic step(input string tag, input bit r, s, st_i, h, b,
                        input logic [15:0] off, input bit j, input logic [15:0] ja,
                        input bit glitch = 0);
        exp_t e;
        @(negedge clk);
        start = s; stall = st_i; halt = h; br_taken = b;
        br_offset = off; jmp = j; jmp_addr = ja;
        if (glitch && !r) begin
            rst = 1'b1; #2; rst = 1'b0;
        end else begin
            rst = r;
        end
        model(r, s, st_i, h, b, int'(off), j, int'(ja));
        e.st = m_mode; e.pc = m_pc; e.en = m_en; e.fl = m_fl; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0);
    endtask

    // Monitor: after every rising edge, check the DUT against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (int'(state) !== e.st || int'(pc_next) !== e.pc ||
                    pc_en !== e.en || flush !== e.fl) begin
                    bad++;
                    $display("FAIL %s: got st=%0d pc=%h en=%b fl=%b want st=%0d pc=%h en=%b fl=%b",
                             e.tag, state, pc_next, pc_en, flush, e.st, e.pc[15:0], e.en, e.fl);
                end
            end
        end
    end

    initial begin
        bit r, s, sl, h, b, j, g;
        rst = 1'b1; start = 0; stall = 0; halt = 0; br_taken = 0; jmp = 0;
        br_offset = 0; jmp_addr = 0;

        // Reset state, then start and sequential increments.
        step("reset", 1, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        step("idle_ignores", 0, 0, 1, 1, 1, 16'h5, 1, 16'h1234);
        step("start", 0, 1, 0, 0, 0, 16'h0, 0, 16'h0);
        idle_step("inc1");
        idle_step("inc2");
        step("start_in_run", 0, 1, 0, 0, 0, 16'h0, 0, 16'h0);

        // Increment up to 0x0010, stall for 3 cycles, then resume.
        while (m_pc != 16) idle_step("inc_to_10");
        repeat (3) step("stall", 0, 0, 1, 0, 0, 16'h0, 0, 16'h0);
        idle_step("resume");

        // Branch backward from 0x0020.
        step("jmp20", 0, 0, 0, 0, 0, 16'h0, 1, 16'h0020);
        step("br_back", 0, 0, 0, 0, 1, 16'hFFF0, 0, 16'h0);
        idle_step("after_br");

        // Jump beats branch and stall. Then back-to-back redirects.
        step("jmp_wins", 0, 0, 1, 0, 1, 16'h0100, 1, 16'h00FF);
        step("b2b_br", 0, 0, 0, 0, 1, 16'h0002, 0, 16'h0);
        step("b2b_jmp", 0, 0, 0, 0, 0, 16'h0, 1, 16'h0002);
        step("br_wrap", 0, 0, 0, 0, 1, 16'hFFFC, 0, 16'h0);
        step("stall_then", 0, 0, 1, 0, 0, 16'h0, 0, 16'h0);
        step("jmp_from_stall", 0, 0, 1, 0, 0, 16'h0, 1, 16'hFFFF);

        // Wrap from 0xFFFF, then halt; HALT absorbs everything except rst.
        idle_step("wrap");
        step("halt", 0, 0, 0, 1, 0, 16'h0, 0, 16'h0);
        step("halt_abs", 0, 1, 0, 0, 1, 16'h3, 1, 16'h0055);
        step("halt_abs2", 0, 1, 1, 1, 0, 16'h0, 0, 16'h0, 1);

        // Reset aborts a pending branch.
        step("rst_h", 1, 0, 0, 0, 0, 16'h0, 0, 16'h0);
        step("start2", 0, 1, 0, 0, 0, 16'h0, 0, 16'h0);
        while (m_pc != 16'h42) idle_step("inc_to_42");
        step("rst_br", 1, 0, 0, 0, 1, 16'h0010, 0, 16'h0);
        idle_step("post_rst");

        // Randomised traffic, including rst pulses between edges.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 79) == 0);
            b  = ($urandom_range(0, 6) == 0);
            j  = ($urandom_range(0, 9) == 0);
            g  = ($urandom_range(0, 19) == 0);
            step("random", r, s, sl, h, b, 16'($urandom), j, 16'($urandom), g);
        end

        @(negedge clk);
        rst = 1'b0; start = 0; stall = 0; halt = 0; br_taken = 0; jmp = 0;
        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
